// File: rtl/flash_seq_if.sv
// Command/response handshake between the SPI register file and flash_seq_ctrl.
// master: command issuer (register file / bench); slave: flash_seq_ctrl.
//   cmd_valid/cmd_ready  command handshake, accepted when both high
//   cmd_op               0=READ 1=PROGRAM 2=SECTOR_ERASE 3=CHIP_ERASE
//   cmd_addr/cmd_wdata   byte/sector address and program data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata/rsp_err    read data or last polled byte, failure flag
interface flash_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [18:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/flash_seq_ctrl.sv
// Parallel boot-flash sequencer: turns one-shot READ/PROGRAM/SECTOR_ERASE/
// CHIP_ERASE commands into JEDEC bus cycles with fclk-counted timing, polls
// DQ7/DQ5 for completion and returns one response per command.
// Ports:
//   fclk, rst      clock, asynchronous active-high reset
//   cmd            flash_seq_if.slave command/response handshake
//   flash_a        ROM address
//   flash_cs/oe/we active-high strobes
//   flash_dout     write data, driven onto D when flash_dout_en is high
//   flash_din      D bus input
// Optional: define FLASH_ERR_RESET_EN to issue a (000,F0) read-reset write
// after a failed program/erase, before the response.
module flash_seq_ctrl #(
    parameter int unsigned T_SU = 3,
    parameter int unsigned T_WP = 4,
    parameter int unsigned T_RD = 4,
    parameter int unsigned TO_W = 24
) (
    input  logic        fclk,
    input  logic        rst,
    flash_seq_if.slave  cmd,
    output logic [18:0] flash_a,
    output logic        flash_cs,
    output logic        flash_oe,
    output logic        flash_we,
    output logic [7:0]  flash_dout,
    output logic        flash_dout_en,
    input  logic [7:0]  flash_din
);

    localparam int unsigned A_W    = 19;
    localparam int unsigned D_W    = 8;
    localparam int unsigned T_MAX1 = (T_SU > T_WP) ? T_SU : T_WP;
    localparam int unsigned T_MAX  = (T_MAX1 > T_RD) ? T_MAX1 : T_RD;
    localparam int unsigned CNT_W  = (T_MAX < 3) ? 1 : $clog2(T_MAX);

    localparam logic [CNT_W-1:0] SU_LOAD = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] WP_LOAD = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(T_RD - 1);
    localparam logic [TO_W-1:0]  TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_PROG   = 2'd1;
    localparam logic [1:0] OP_SERASE = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_SU, S_WR_PULSE, S_WR_HOLD, S_WR_GAP,
        S_RD_TURN, S_RD_ACT, S_RD_GAP, S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       op_q, op_d;
    logic [A_W-1:0]   addr_q, addr_d;
    logic [D_W-1:0]   wdata_q, wdata_d;
    logic [D_W-1:0]   rdata_q;
    logic             retry_q, retry_d;
    logic             err_q, err_d;
    logic             err_rst_q, err_rst_d;

    logic [2:0]       last_step;
    logic             exp_dq7;
    logic             finish;
    logic             fin_err;

    logic [A_W-1:0]   a_d;
    logic [D_W-1:0]   dout_d;
    logic             cs_d, oe_d, we_d, den_d;

    // Index of the final command write cycle for the latched op
    always_comb begin
        last_step = 3'd3;
        if (op_q == OP_SERASE)   last_step = 3'd5;
        else if (op_q != OP_PROG) last_step = 3'd6;
    end

    assign exp_dq7 = (op_q == OP_PROG) ? wdata_q[7] : 1'b1;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        to_d      = to_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        retry_d   = retry_q;
        err_d     = err_q;
        err_rst_d = err_rst_q;
        finish    = 1'b0;
        fin_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    op_d      = cmd.cmd_op;
                    addr_d    = cmd.cmd_addr;
                    wdata_d   = cmd.cmd_wdata;
                    step_d    = 3'd0;
                    to_d      = '0;
                    retry_d   = 1'b0;
                    err_d     = 1'b0;
                    err_rst_d = 1'b0;
                    if (cmd.cmd_op == OP_READ) begin
                        state_d = S_RD_ACT;
                        cnt_d   = RD_LOAD;
                    end else begin
                        state_d = S_WR_SU;
                        cnt_d   = SU_LOAD;
                    end
                end
            end
            S_WR_SU: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_PULSE;
                    cnt_d   = WP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_HOLD;
                    cnt_d   = SU_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                if (cnt_q == '0) state_d = S_WR_GAP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_WR_GAP: begin
                if (err_rst_q) begin
                    state_d = S_RESP;
                end else if (step_q == last_step) begin
                    state_d = S_RD_TURN;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_WR_SU;
                    cnt_d   = SU_LOAD;
                end
            end
            S_RD_TURN: begin
                state_d = S_RD_ACT;
                cnt_d   = RD_LOAD;
            end
            S_RD_ACT: begin
                if (cnt_q == '0) state_d = S_RD_GAP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RD_GAP: begin
                // Status poll decision on the byte sampled at the end of RD_ACT
                if (op_q == OP_READ) begin
                    state_d = S_RESP;
                end else if (rdata_q[7] == exp_dq7) begin
                    finish = 1'b1;
                end else if (retry_q) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else if (rdata_q[5]) begin
                    retry_d = 1'b1;
                    state_d = S_RD_ACT;
                    cnt_d   = RD_LOAD;
                end else if (to_q == TO_LAST) begin
                    to_d    = to_q + TO_W'(1);
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    to_d    = to_q + TO_W'(1);
                    state_d = S_RD_ACT;
                    cnt_d   = RD_LOAD;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            err_d   = fin_err;
            state_d = S_RESP;
`ifdef FLASH_ERR_RESET_EN
            if (fin_err) begin
                err_rst_d = 1'b1;
                state_d   = S_WR_SU;
                cnt_d     = SU_LOAD;
            end
`endif
        end
    end

    // Next values of the registered flash pins, decoded from the next state
    always_comb begin
        a_d    = flash_a;
        dout_d = flash_dout;
        cs_d   = 1'b0;
        oe_d   = 1'b0;
        we_d   = 1'b0;
        den_d  = 1'b0;

        case (state_d)
            S_WR_SU, S_WR_PULSE, S_WR_HOLD: begin
                cs_d  = 1'b1;
                den_d = 1'b1;
                we_d  = (state_d == S_WR_PULSE);
                // Command table; unlock cycles leave a[18:11] at zero
                a_d    = A_W'(19'h555);
                dout_d = 8'hAA;
                if (err_rst_d) begin
                    a_d    = '0;
                    dout_d = 8'hF0;
                end else if (op_d == OP_PROG) begin
                    case (step_d)
                        3'd0:    begin a_d = A_W'(19'h555); dout_d = 8'hAA;   end
                        3'd1:    begin a_d = A_W'(19'h2AA); dout_d = 8'h55;   end
                        3'd2:    begin a_d = A_W'(19'h555); dout_d = 8'hA0;   end
                        default: begin a_d = addr_d;        dout_d = wdata_d; end
                    endcase
                end else begin
                    case (step_d)
                        3'd0:    begin a_d = A_W'(19'h555); dout_d = 8'hAA; end
                        3'd1:    begin a_d = A_W'(19'h2AA); dout_d = 8'h55; end
                        3'd2:    begin a_d = A_W'(19'h555); dout_d = 8'h80; end
                        3'd3:    begin a_d = A_W'(19'h555); dout_d = 8'hAA; end
                        3'd4:    begin a_d = A_W'(19'h2AA); dout_d = 8'h55; end
                        3'd5:    begin a_d = addr_d;        dout_d = 8'h30; end
                        default: begin a_d = A_W'(19'h555); dout_d = 8'h10; end
                    endcase
                end
            end
            S_RD_TURN: a_d = addr_d;
            S_RD_ACT: begin
                a_d  = addr_d;
                cs_d = 1'b1;
                oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            step_q        <= '0;
            to_q          <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            retry_q       <= 1'b0;
            err_q         <= 1'b0;
            err_rst_q     <= 1'b0;
            flash_a       <= '0;
            flash_cs      <= 1'b0;
            flash_oe      <= 1'b0;
            flash_we      <= 1'b0;
            flash_dout    <= '0;
            flash_dout_en <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_rdata <= '0;
            cmd.rsp_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            to_q          <= to_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            retry_q       <= retry_d;
            err_q         <= err_d;
            err_rst_q     <= err_rst_d;
            if (state_q == S_RD_ACT && cnt_q == '0) rdata_q <= flash_din;
            flash_a       <= a_d;
            flash_cs      <= cs_d;
            flash_oe      <= oe_d;
            flash_we      <= we_d;
            flash_dout    <= dout_d;
            flash_dout_en <= den_d;
            cmd.cmd_ready <= (state_d == S_IDLE);
            cmd.rsp_valid <= (state_d == S_RESP);
            cmd.rsp_err   <= (state_d == S_RESP) && err_d;
            if (state_d == S_RESP) cmd.rsp_rdata <= rdata_q;
        end
    end

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Directed bench for flash_seq_ctrl with a small behavioural flash model.
module tb_flash_seq_ctrl;
    localparam int unsigned T_SU   = 3;
    localparam int unsigned T_WP   = 4;
    localparam int unsigned T_RD   = 4;
    localparam int unsigned TO_W   = 4;
    localparam int          WR_CYC = 2 * T_SU + T_WP + 1;
`ifdef FLASH_ERR_RESET_EN
    localparam bit ERR_RST = 1'b1;
`else
    localparam bit ERR_RST = 1'b0;
`endif

    logic        fclk = 1'b0;
    logic        rst;
    logic [18:0] flash_a;
    logic        flash_cs, flash_oe, flash_we, flash_dout_en;
    logic [7:0]  flash_dout, flash_din;

    flash_seq_if bus ();

    flash_seq_ctrl #(.T_SU(T_SU), .T_WP(T_WP), .T_RD(T_RD), .TO_W(TO_W)) dut (
        .fclk          (fclk),
        .rst           (rst),
        .cmd           (bus),
        .flash_a       (flash_a),
        .flash_cs      (flash_cs),
        .flash_oe      (flash_oe),
        .flash_we      (flash_we),
        .flash_dout    (flash_dout),
        .flash_dout_en (flash_dout_en),
        .flash_din     (flash_din)
    );

    always #5 fclk = ~fclk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge fclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash model: first bad_n reads return bad_val, later reads good_val
    int          bad_n = 0;
    logic [7:0]  bad_val = 8'h00;
    logic [7:0]  good_val = 8'h00;
    int          n_reads = 0;
    int          cs_run = 0;
    int          we_run = 0;
    int          viol = 0;
    int          rsp_cnt = 0;
    bit          seen_we = 1'b0;
    bit          we_prev = 1'b0;
    logic [18:0] wlog_a[$];
    logic [7:0]  wlog_d[$];

    assign flash_din = (n_reads < bad_n) ? bad_val : good_val;

    // Bus monitor: logs write cycles, counts reads, checks strobe widths
    always @(negedge fclk) begin
        if (flash_oe && (flash_dout_en || flash_we)) viol++;
        if (flash_cs) begin
            cs_run++;
            if (flash_we) seen_we = 1'b1;
        end else if (cs_run != 0) begin
            if (seen_we) begin
                if (cs_run != int'(2 * T_SU + T_WP)) viol++;
            end else begin
                n_reads++;
                if (cs_run != int'(T_RD)) viol++;
            end
            cs_run  = 0;
            seen_we = 1'b0;
        end
        if (flash_we) begin
            if (!we_prev) begin
                wlog_a.push_back(flash_a);
                wlog_d.push_back(flash_dout);
            end
            we_run++;
        end else if (we_run != 0) begin
            if (we_run != int'(T_WP)) viol++;
            we_run = 0;
        end
        we_prev = flash_we;
        if (bus.rsp_valid) rsp_cnt++;
    end

    typedef struct {
        logic [1:0]  op;
        logic [18:0] addr;
        logic [7:0]  wdata;
        int          bad_n;
        logic [7:0]  bad_val;
        logic [7:0]  good_val;
        int          exp_reads;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic int base_writes(input logic [1:0] op);
        case (op)
            2'd1:    return 4;
            2'd2:    return 6;
            2'd3:    return 7;
            default: return 0;
        endcase
    endfunction

    // Expected JEDEC write cycle i of a command
    function automatic logic [26:0] exp_wr(input logic [1:0] op, input int i,
                                           input logic [18:0] addr, input logic [7:0] wd);
        if (i >= base_writes(op)) return {19'h0, 8'hF0};
        if (op == 2'd1) begin
            case (i)
                0:       return {19'h555, 8'hAA};
                1:       return {19'h2AA, 8'h55};
                2:       return {19'h555, 8'hA0};
                default: return {addr, wd};
            endcase
        end
        case (i)
            0:       return {19'h555, 8'hAA};
            1:       return {19'h2AA, 8'h55};
            2:       return {19'h555, 8'h80};
            3:       return {19'h555, 8'hAA};
            4:       return {19'h2AA, 8'h55};
            5:       return {addr, 8'h30};
            default: return {19'h555, 8'h10};
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int   t0, lat, n_wr, exp_lat;
        bit   got;
        logic [26:0] ew;
        @(posedge fclk);
        #1;
        bad_n    = v.bad_n;
        bad_val  = v.bad_val;
        good_val = v.good_val;
        n_reads  = 0;
        viol     = 0;
        rsp_cnt  = 0;
        wlog_a.delete();
        wlog_d.delete();
        check({tag, ".ready_idle"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        @(posedge fclk);
        #1;
        t0 = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 19'h7FFFF;
        bus.cmd_wdata = 8'hFF;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge fclk);
            if (bus.rsp_valid) got = 1'b1;
        end
        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        if (!got) return;
        lat  = cyc - t0;
        n_wr = base_writes(v.op) + ((v.exp_err && ERR_RST) ? 1 : 0);
        exp_lat = n_wr * WR_CYC + ((base_writes(v.op) > 0) ? 1 : 0) + v.exp_reads * int'(T_RD + 1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
        check({tag, ".err"}, 32'(bus.rsp_err), 32'(v.exp_err));
        check({tag, ".ready_in_rsp"}, 32'(bus.cmd_ready), 32'd0);
        @(negedge fclk);
        check({tag, ".ready_after"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, ".rsp_pulses"}, 32'(rsp_cnt), 32'd1);
        check({tag, ".reads"}, 32'(n_reads), 32'(v.exp_reads));
        check({tag, ".writes"}, 32'(wlog_a.size()), 32'(n_wr));
        check({tag, ".timing"}, 32'(viol), 32'd0);
        for (int i = 0; i < n_wr && i < wlog_a.size(); i++) begin
            ew = exp_wr(v.op, i, v.addr, v.wdata);
            check($sformatf("%s.wr%0d", tag, i), {5'd0, wlog_a[i], wlog_d[i]}, {5'd0, ew});
        end
    endtask

    initial begin
        bool_dummy();
    end

    task automatic bool_dummy();
    endtask

    initial begin
        bit seen;
        //                op     addr      wdata  bad_n bad    good   reads rdata  err
        vecs[0] = '{2'd0, 19'h71234, 8'h00,    0, 8'h00, 8'h5A,  1, 8'h5A, 1'b0};
        vecs[1] = '{2'd1, 19'h00100, 8'h3C,   10, 8'hC3, 8'h3C, 11, 8'h3C, 1'b0};
        vecs[2] = '{2'd2, 19'h40000, 8'h00,    5, 8'h00, 8'hFF,  6, 8'hFF, 1'b0};
        vecs[3] = '{2'd1, 19'h00200, 8'h80, 1000, 8'h20, 8'h20,  2, 8'h20, 1'b1};
        vecs[4] = '{2'd3, 19'h12345, 8'h00, 1000, 8'h00, 8'h00, 15, 8'h00, 1'b1};
        vecs[5] = '{2'd1, 19'h00020, 8'h00,    1, 8'hA0, 8'h00,  2, 8'h00, 1'b0};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 19'h0;
        bus.cmd_wdata = 8'h0;
        repeat (3) @(negedge fclk);
        check("rst.ready", 32'(bus.cmd_ready), 32'd1);
        check("rst.strobes", 32'({flash_cs, flash_oe, flash_we, flash_dout_en, bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("rst.addr", 32'(flash_a), 32'd0);
        check("rst.data", 32'({flash_dout, bus.rsp_rdata}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge fclk);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Reset in the middle of a program write pulse
        @(posedge fclk);
        #1;
        rsp_cnt       = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_addr  = 19'h00100;
        bus.cmd_wdata = 8'h3C;
        @(posedge fclk);
        #1;
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge fclk);
            if (flash_we) seen = 1'b0 | 1'b1;
        end
        check("abort.we_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.strobes", 32'({flash_we, flash_cs, flash_dout_en, flash_oe}), 32'd0);
        check("abort.ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(negedge fclk);
        rst = 1'b0;
        repeat (20) @(negedge fclk);
        check("abort.no_rsp", 32'(rsp_cnt), 32'd0);
        check("abort.ready_after", 32'(bus.cmd_ready), 32'd1);
        run_vec('{2'd0, 19'h00003, 8'h00, 0, 8'h00, 8'h96, 1, 8'h96, 1'b0}, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
